// File: rtl/palette_lut.sv
// palette_lut: CPU-writable colour lookup table with a hardware init sweep,
// greyscale and colour-emphasis modes, and a fixed two-stage read pipeline.
// Reads are accepted every cycle; results appear two cycles after request.
module palette_lut #(
  parameter int                  IDX_W = 6,
  parameter int                  CH_W  = 4,
  parameter logic [3*CH_W-1:0]   BLANK = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               init_req,
  output logic               busy,
  input  logic               wr_en,
  input  logic [IDX_W-1:0]   wr_addr,
  input  logic [3*CH_W-1:0]  wr_data,
  input  logic               rd_valid_i,
  input  logic [IDX_W-1:0]   rd_addr,
  input  logic               greyscale,
  input  logic [2:0]         emph,
  output logic               rd_valid_o,
  output logic [3*CH_W-1:0]  rgb_o
);

  localparam int RGB_W = 3 * CH_W;
  localparam int DEPTH = 2 ** IDX_W;
  // Greyscale forces the low nibble of the index to zero (hue 0 of the row).
  localparam logic [IDX_W-1:0] GREY_MASK = ~(IDX_W'(4'hF));

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_t;

  // Attenuate one channel by a quarter: v - v/4 never underflows.
  function automatic logic [CH_W-1:0] att(input logic [CH_W-1:0] v);
    return v - (v >> 2);
  endfunction

  // Emphasis: emph bit c selects channel c (0=R,1=G,2=B); when any bit is
  // set the non-emphasised channels are dimmed, and all-ones dims everything.
  function automatic logic [RGB_W-1:0] apply_emph(input logic [RGB_W-1:0] rgb,
                                                  input logic [2:0]       em);
    logic [RGB_W-1:0] res;
    logic [CH_W-1:0]  v;
    logic             cut;
    res = rgb;
    for (int c = 0; c < 3; c++) begin
      v   = rgb[(2-c)*CH_W +: CH_W];
      cut = (em == 3'b111) || ((em != 3'b000) && !em[c]);
      res[(2-c)*CH_W +: CH_W] = cut ? att(v) : v;
    end
    return res;
  endfunction

  logic [RGB_W-1:0] mem_r [DEPTH];

  state_t            state_r, state_nxt_s;
  logic [IDX_W-1:0]  cnt_r, cnt_nxt_s;
  logic              busy_r;

  logic              tbl_we_s;
  logic [IDX_W-1:0]  tbl_waddr_s;
  logic [RGB_W-1:0]  tbl_wdata_s;
  logic              wr_ok_s;

  logic [IDX_W-1:0]  eff_addr_s;
  logic [RGB_W-1:0]  rd_data_s;

  logic              s1_valid_r;
  logic [RGB_W-1:0]  s1_data_r;
  logic [2:0]        s1_emph_r;
  logic              rd_valid_r;
  logic [RGB_W-1:0]  rgb_r;

  // Init FSM next state, sweep counter and the single table write port mux.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    tbl_we_s    = 1'b0;
    tbl_waddr_s = wr_addr;
    tbl_wdata_s = wr_data;
    wr_ok_s     = 1'b0;
    case (state_r)
      IDLE: begin
        wr_ok_s  = wr_en;
        tbl_we_s = wr_en;
        if (init_req) begin
          state_nxt_s = SWEEP;
          cnt_nxt_s   = '0;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SWEEP: begin
        tbl_we_s    = 1'b1;
        tbl_waddr_s = cnt_r;
        tbl_wdata_s = BLANK;
        if (init_req) begin
          cnt_nxt_s = '0;
        end else if (&cnt_r) begin
          state_nxt_s = IDLE;
          cnt_nxt_s   = '0;
        end else begin
          cnt_nxt_s = cnt_r + IDX_W'(1);
        end
      end
      default: begin
        state_nxt_s = SWEEP;
        cnt_nxt_s   = '0;
      end
    endcase
  end

  // Read address selection and stage-1 data source (blank / bypass / table).
  always_comb begin
    eff_addr_s = greyscale ? (rd_addr & GREY_MASK) : rd_addr;
    if (state_r == SWEEP) begin
      rd_data_s = BLANK;
    end else if (wr_ok_s && (wr_addr == eff_addr_s)) begin
      rd_data_s = wr_data;
    end else begin
      rd_data_s = mem_r[eff_addr_s];
    end
  end

  // Table storage; no reset, the init sweep establishes its contents.
  always_ff @(posedge clk) begin
    if (tbl_we_s) begin
      mem_r[tbl_waddr_s] <= tbl_wdata_s;
    end
  end

  // Control state and both read pipeline stages.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= SWEEP;
      cnt_r      <= '0;
      busy_r     <= 1'b1;
      s1_valid_r <= 1'b0;
      s1_data_r  <= '0;
      s1_emph_r  <= 3'b000;
      rd_valid_r <= 1'b0;
      rgb_r      <= '0;
    end else begin
      state_r    <= state_nxt_s;
      cnt_r      <= cnt_nxt_s;
      busy_r     <= (state_nxt_s == SWEEP);
      s1_valid_r <= rd_valid_i;
      if (rd_valid_i) begin
        s1_data_r <= rd_data_s;
        s1_emph_r <= emph;
      end
      rd_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        rgb_r <= apply_emph(s1_data_r, s1_emph_r);
      end
    end
  end

  assign busy       = busy_r;
  assign rd_valid_o = rd_valid_r;
  assign rgb_o      = rgb_r;

endmodule
